// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam int PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous first-word fall-through FIFO; dout reads 0 while empty.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands when a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the pins, deframes 11-bit
// frames and queues good scan codes for the CPU with a one-cycle interrupt per code.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       SCAN_RD,
  input  logic       ERR_CLR,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_VALID,
  output logic       INTR,
  output logic       FRAME_ERR,
  output logic       OVERFLOW
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PS2_DATA_BITS - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2, clk_filt, clk_filt_d, fall;
  logic [FW-1:0] filt_cnt;

  // Bus idles high, so sync and filter stages reset to 1 to avoid a false edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= PS2Clk;
      clk_s2     <= clk_s1;
      dat_s1     <= PS2Data;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  ps2_state_t               state, state_n;
  logic [PS2_DATA_BITS-1:0] sr, sr_n;
  logic [BW-1:0]            bit_cnt, bit_cnt_n;
  logic [TW-1:0]            tmo, tmo_n;
  logic                     perr, perr_n, push_req, ferr_set;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      tmo     <= '0;
      perr    <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      tmo     <= tmo_n;
      perr    <= perr_n;
    end
  end

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    perr_n    = perr;
    tmo_n     = '0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    if (state != IDLE) tmo_n = fall ? '0 : tmo + 1'b1;
    if (state != IDLE && !fall && tmo == TMO_MAX) begin
      state_n  = IDLE;
      tmo_n    = '0;
      ferr_set = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: if (!dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          sr_n      = {dat_s2, sr[PS2_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = PARITY;
        end
        PARITY: begin
          perr_n  = ~(^sr ^ dat_s2);
          state_n = STOP;
        end
        default: begin
          if (dat_s2 && !perr) push_req = 1'b1;
          else                 ferr_set = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end

  logic fifo_empty, fifo_full, push_ok, ovf_set;

  assign push_ok = push_req & (~fifo_full | SCAN_RD);
  assign ovf_set = push_req & fifo_full & ~SCAN_RD;

  ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PS2_DATA_BITS)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_req),
    .pop   (SCAN_RD),
    .din   (sr),
    .dout  (SCAN_CODE),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign SCAN_VALID = ~fifo_empty;

  // Setting a flag takes priority over ERR_CLR in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INTR      <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      INTR      <= push_ok;
      FRAME_ERR <= ferr_set | (FRAME_ERR & ~ERR_CLR);
      OVERFLOW  <= ovf_set | (OVERFLOW & ~ERR_CLR);
    end
  end

endmodule
